// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level, almost-full/empty thresholds and sticky error flags (SYNC_FIFO_FWFT_EN selects fall-through read).
// Latency: push visible from the next cycle; registered read data one cycle after pop, FWFT head data combinational.
// Backpressure: push rejected while full, pop rejected while empty (both flagged); flush overrides both.
module sync_fifo_flags #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALMOST_FULL_LEVEL  = 14,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read_increment,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     read_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     error_clear
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LVL = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LVL    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LVL    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [ADDRESS_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0] level_w;
    logic                   full_w, empty_w;
    logic                   push_acc, pop_acc;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    // Pointers carry one extra wrap bit so all DEPTH slots are usable.
    always_comb begin
        level_w  = wr_ptr_q - rd_ptr_q;
        full_w   = (level_w == DEPTH_LVL);
        empty_w  = (level_w == '0);
        push_acc = write_increment & ~full_w & ~flush;
        pop_acc  = read_increment & ~empty_w & ~flush;

        wr_ptr_d = wr_ptr_q + {{ADDRESS_WIDTH{1'b0}}, push_acc};
        rd_ptr_d = rd_ptr_q + {{ADDRESS_WIDTH{1'b0}}, pop_acc};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        // A new error in the same cycle as error_clear keeps the flag set.
        overflow_d  = (overflow_q & ~error_clear)  | (write_increment & full_w & ~flush);
        underflow_d = (underflow_q & ~error_clear) | (read_increment & empty_w & ~flush);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; validity comes only from the pointers.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[ADDRESS_WIDTH-1:0]] <= write_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign read_data  = mem_q[rd_ptr_q[ADDRESS_WIDTH-1:0]];
    assign read_valid = ~empty_w;
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_acc;
        if (pop_acc) begin
            rd_data_d = mem_q[rd_ptr_q[ADDRESS_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
`endif

    assign level        = level_w;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (level_w >= AF_LVL);
    assign almost_empty = (level_w <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
